turbo_iter_ctrl: RTL

Iteration sequencer for the 4-lane turbo decoder datapath. It drives the quad read/write address streams through the MAP pipeline and the 4-lane interleaver register stage, and it alternates half-iterations between natural order (decoder 1) and interleaved order (decoder 2). It counts full iterations up to a configured maximum and reports completion with a one-cycle done pulse. It sits between the frame-level control and the extrinsic-memory/MAP/interleaver datapath.

---
 rtl/turbo_pkg.sv | 20 ++
 rtl/turbo_addr_delay.sv | 40 ++++
 rtl/turbo_iter_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/turbo_pkg.sv
// Shared types for the turbo iteration sequencer: FSM states, iteration counter width, bit-reverse.
package turbo_pkg;

  localparam int ITER_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    TURN  = 2'd3
  } state_e;

  // Reverses the low w bits of v; bits above w must be zero and are shifted out.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = {<<{v}};
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/turbo_addr_delay.sv
// DEPTH-stage shift register carrying {valid, addr, tag}; fixed DEPTH-cycle latency, no stall.
module turbo_addr_delay #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          clr_n_i,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_i,
  input  logic          tag_i,
  output logic          vld_o,
  output logic [AW-1:0] addr_o,
  output logic          tag_o
);

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] addr;
    logic          tag;
  } stage_t;

  stage_t pipe_q [DEPTH];
  stage_t in_s;

  assign in_s = '{vld: vld_i, addr: addr_i, tag: tag_i};

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= in_s;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vld_o  = pipe_q[DEPTH-1].vld;
  assign addr_o = pipe_q[DEPTH-1].addr;
  assign tag_o  = pipe_q[DEPTH-1].tag;

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration sequencer: natural/interleaved half-iterations, PIPE_LAT read->write delay.
// Optional TURBO_EARLY_STOP_EN: conv_ok at the decoder-2 turn ends the frame early.
module turbo_iter_ctrl
  import turbo_pkg::*;
#(
  parameter  int QUADS    = 256,
  parameter  int PIPE_LAT = 4,
  parameter  int MAX_ITER = 8,
  localparam int ADDR_W   = $clog2(QUADS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              conv_ok,
  output logic              busy,
  output logic              done,
  output logic              half,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              perm_sel
);

  // One counter serves both the quad index in READ and the drain wait.
  localparam int CNT_MAX = (QUADS > PIPE_LAT) ? QUADS : PIPE_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              half_q, half_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              stop_req;
  logic              finish;
  logic [ADDR_W-1:0] addr_nat;

`ifdef TURBO_EARLY_STOP_EN
  assign stop_req = conv_ok;
`else
  logic unused_conv_ok;
  assign unused_conv_ok = conv_ok;
  assign stop_req       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    iter_d  = iter_q;
    rd_en   = 1'b0;
    done    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          cnt_d   = '0;
          half_d  = 1'b0;
          iter_d  = '0;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (cnt_q == CNT_W'(QUADS - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // Last write leaves the delay line PIPE_LAT cycles after the last read.
        if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
          state_d = TURN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN: begin
        finish = half_q && ((iter_q == ITER_W'(MAX_ITER - 1)) || stop_req);
        if (half_q) iter_d = iter_q + 1'b1;
        if (finish) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          half_d  = ~half_q;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_nat = cnt_q[ADDR_W-1:0];
  assign rd_addr  = !rd_en  ? '0 :
                    half_q  ? ADDR_W'(bit_rev(32'(addr_nat), ADDR_W)) : addr_nat;
  assign busy     = (state_q != IDLE);
  assign half     = half_q;
  assign iter_cnt = iter_q;

  // Tag is the interleave select: set only for valid decoder-1 writes.
  turbo_addr_delay #(
    .DEPTH (PIPE_LAT),
    .AW    (ADDR_W)
  ) u_delay (
    .clk     (clk),
    .clr_n_i (rst),
    .vld_i   (rd_en),
    .addr_i  (rd_addr),
    .tag_i   (rd_en & ~half_q),
    .vld_o   (wr_en),
    .addr_o  (wr_addr),
    .tag_o   (perm_sel)
  );

endmodule
